// File: rtl/rom_search_ctrl.sv
// rom_search_ctrl
//   Binary-search sequencer for a sorted, combinational lookup ROM. One search
//   runs at a time. The block owns the ROM address bus and reports hit/miss, the
//   matching index (or the insertion point on a miss) and the number of probes.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset_n      synchronous active-low reset
//   start        search request, only looked at while idle
//   key          value to find, captured when start is accepted
//   rom_addr     registered ROM address
//   rom_data     combinational ROM read data for rom_addr
//   busy         high while a search is in progress
//   done         one-cycle pulse when found/index/probe_count are valid
//   found        1 when the key was present in the window
//   index        hit: matching address; miss: insertion point (0..LAST_ADDR+1)
//   probe_count  ROM probes used by the last search
module rom_search_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LAST_ADDR  = 4095
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] key,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [ADDR_WIDTH:0]   index,
    output logic [4:0]            probe_count
);

    // lo/hi/mid carry one extra bit so a miss above the last entry can report
    // LAST_ADDR+1 as the insertion point without wrapping.
    localparam int                  PW     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] ZERO_W = {PW{1'b0}};
    localparam logic [ADDR_WIDTH:0] ONE_W  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LAST_W = PW'(LAST_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH:0]     lo_r;
    logic [ADDR_WIDTH:0]     hi_r;
    logic [ADDR_WIDTH:0]     mid_r;
    logic [DATA_WIDTH-1:0]   key_r;
    logic [ADDR_WIDTH:0]     mid_s;

    // Midpoint of the current window; lo <= hi always, so hi-lo never underflows.
    always_comb begin
        mid_s = ZERO_W;
        mid_s = lo_r + ((hi_r - lo_r) >> 1'b1);
    end

    // Search sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            lo_r        <= ZERO_W;
            hi_r        <= ZERO_W;
            mid_r       <= ZERO_W;
            key_r       <= {DATA_WIDTH{1'b0}};
            rom_addr    <= {ADDR_WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            index       <= ZERO_W;
            probe_count <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_r       <= key;
                        lo_r        <= ZERO_W;
                        hi_r        <= LAST_W;
                        probe_count <= 5'd0;
                        busy        <= 1'b1;
                        state_r     <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    // rom_addr only moves here, so PROBE sees settled ROM data.
                    mid_r       <= mid_s;
                    rom_addr    <= mid_s[ADDR_WIDTH-1:0];
                    probe_count <= probe_count + 5'd1;
                    state_r     <= PROBE;
                end
                PROBE: begin
                    if (rom_data == key_r) begin
                        found   <= 1'b1;
                        index   <= mid_r;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (rom_data < key_r) begin
                        // Window exhausted on the upper side: key belongs just above mid.
                        if (mid_r == hi_r) begin
                            found   <= 1'b0;
                            index   <= mid_r + ONE_W;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            lo_r    <= mid_r + ONE_W;
                            state_r <= CALC;
                        end
                    end else begin
                        // Window exhausted on the lower side: key belongs at lo.
                        if (mid_r == lo_r) begin
                            found   <= 1'b0;
                            index   <= lo_r;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            hi_r    <= mid_r - ONE_W;
                            state_r <= CALC;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; it is accepted next cycle.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_search_ctrl.sv
// Bench for rom_search_ctrl: a small window (LAST_ADDR=7, odd values 1..15)
// for directed and random cases, and a full default window (rom[a]=a>>4)
// for the exhaustive key sweep.
module tb_rom_search_ctrl;

    logic        clk;
    logic        reset_n;

    logic        start_a, start_b;
    logic [7:0]  key_a, key_b;
    logic [11:0] rom_addr_a, rom_addr_b;
    logic [7:0]  rom_data_a, rom_data_b;
    logic        busy_a, busy_b, done_a, done_b, found_a, found_b;
    logic [12:0] index_a, index_b;
    logic [4:0]  probe_count_a, probe_count_b;

    int checks = 0;
    int errors = 0;

    // Reference ROM contents for both windows.
    function automatic int rom_val(input bit big, input int a);
        if (big) return a >> 4;
        else if (a <= 7) return 2 * a + 1;
        else return 255;
    endfunction

    always_comb rom_data_a = 8'(rom_val(1'b0, int'(rom_addr_a)));
    always_comb rom_data_b = 8'(rom_val(1'b1, int'(rom_addr_b)));

    rom_search_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .LAST_ADDR(7)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .key(key_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .busy(busy_a), .done(done_a),
        .found(found_a), .index(index_a), .probe_count(probe_count_a)
    );

    rom_search_ctrl dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .key(key_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .busy(busy_b), .done(done_b),
        .found(found_b), .index(index_b), .probe_count(probe_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Probe count of a textbook binary search over the window.
    function automatic int ref_probes(input bit big, input int k);
        int lo, hi, mid, v, n;
        lo = 0;
        hi = big ? 4095 : 7;
        n = 0;
        while (n < 32) begin
            mid = (lo + hi) / 2;
            n++;
            v = rom_val(big, mid);
            if (v == k) break;
            else if (v < k) begin
                if (mid == hi) break;
                lo = mid + 1;
            end else begin
                if (mid == lo) break;
                hi = mid - 1;
            end
        end
        return n;
    endfunction

    task automatic issue(input bit big, input int k);
        @(negedge clk);
        if (big) begin start_b = 1'b1; key_b = 8'(k); end
        else     begin start_a = 1'b1; key_a = 8'(k); end
    endtask

    // Acceptance edge, then wait for done; returns one edge after done (idle).
    task automatic wait_result(input bit big, input bit hold, input bit poke,
                               output logic [31:0] f, output logic [31:0] idx,
                               output logic [31:0] pc, output logic [31:0] addr,
                               output int lat);
        @(posedge clk); #1;
        lat = 1;
        chk("accept_busy", big ? busy_b : busy_a, 1);
        if (!hold) begin
            if (big) start_b = 1'b0; else start_a = 1'b0;
        end
        while ((big ? done_b : done_a) !== 1'b1 && lat < 40) begin
            if (poke && lat == 2) begin start_a = 1'b1; key_a = 8'd15; end
            if (poke && lat == 3) start_a = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("done_timeout", big ? done_b : done_a, 1);
        chk("busy_at_done", big ? busy_b : busy_a, 0);
        f    = big ? found_b : found_a;
        idx  = big ? index_b : index_a;
        pc   = big ? probe_count_b : probe_count_a;
        addr = big ? rom_addr_b : rom_addr_a;
        @(posedge clk); #1;
        chk("done_width", big ? done_b : done_a, 0);
        chk("idle_busy", big ? busy_b : busy_a, 0);
    endtask

    task automatic run_a(input bit do_issue, input bit poke, input int k,
                         input int ef, input int eidx, input int epc, input int eaddr);
        logic [31:0] f, idx, pc, addr;
        int lat;
        if (do_issue) issue(1'b0, k);
        wait_result(1'b0, 1'b0, poke, f, idx, pc, addr, lat);
        chk($sformatf("found_k%0d", k), f, ef);
        chk($sformatf("index_k%0d", k), idx, eidx);
        chk($sformatf("probes_k%0d", k), pc, epc);
        chk($sformatf("latency_k%0d", k), lat, 2 * epc + 1);
        if (eaddr >= 0) chk($sformatf("last_probe_k%0d", k), addr, eaddr);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_found", found_a, ef);
        chk("hold_index", index_a, eidx);
        chk("hold_probes", probe_count_a, epc);
    endtask

    initial begin
        logic [31:0] f, idx, pc, addr;
        int lat, k, ek;

        // Reset held with start asserted.
        reset_n = 1'b0;
        start_a = 1'b1; key_a = 8'd7;
        start_b = 1'b0; key_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_found", found_a, 0);
        chk("rst_index", index_a, 0);
        chk("rst_addr", rom_addr_a, 0);
        chk("rst_probes", probe_count_a, 0);
        chk("rst_b_busy", busy_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_a(1'b0, 1'b0, 7, 1, 3, 1, 3);

        // Boundary hits and misses.
        run_a(1'b1, 1'b0, 1, 1, 0, 3, 0);
        run_a(1'b1, 1'b0, 15, 1, 7, 4, 7);
        run_a(1'b1, 1'b0, 0, 0, 0, 3, 0);
        run_a(1'b1, 1'b0, 16, 0, 8, 4, 7);
        run_a(1'b1, 1'b0, 8, 0, 4, 3, 4);

        // start/key poked while busy must not disturb the search for 1.
        run_a(1'b1, 1'b1, 1, 1, 0, 3, 0);

        // start held high: a new search every cycle after done.
        issue(1'b0, 9);
        for (int r = 0; r < 3; r++) begin
            wait_result(1'b0, 1'b1, 1'b0, f, idx, pc, addr, lat);
            chk("held_found", f, 1);
            chk("held_index", idx, 4);
            chk("held_probes", pc, 3);
            chk("held_latency", lat, 7);
        end
        start_a = 1'b0;

        // Random keys against arithmetic expectations for the odd-value ROM.
        for (int r = 0; r < 16; r++) begin
            k = int'($urandom_range(0, 20));
            ek = (k / 2 < 8) ? k / 2 : 8;
            run_a(1'b1, 1'b0, k, ((k % 2) == 1 && k <= 15) ? 1 : 0, ek,
                  ref_probes(1'b0, k), -1);
        end

        // Reset during the second probe of a search for 15.
        issue(1'b0, 15);
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_found", found_a, 0);
        chk("abort_index", index_a, 0);
        chk("abort_addr", rom_addr_a, 0);
        chk("abort_probes", probe_count_a, 0);
        reset_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done_a, 0);
        end
        run_a(1'b1, 1'b0, 9, 1, 4, 3, 4);

        // Exhaustive sweep over the full default window.
        for (int kk = 0; kk < 256; kk++) begin
            issue(1'b1, kk);
            wait_result(1'b1, 1'b0, 1'b0, f, idx, pc, addr, lat);
            chk($sformatf("sweep_found_k%0d", kk), f, 1);
            chk($sformatf("sweep_rom_at_index_k%0d", kk), rom_val(1'b1, int'(idx)), kk);
            chk($sformatf("sweep_probes_k%0d", kk), pc, ref_probes(1'b1, kk));
            chk($sformatf("sweep_probe_limit_k%0d", kk), (pc <= 32'd12) ? 1 : 0, 1);
            chk($sformatf("sweep_latency_k%0d", kk), lat, 2 * ref_probes(1'b1, kk) + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
